// File: rtl/slave_arbiter_pkg.sv
// Shared definitions for the slave-port arbiter: status codes, command codes, FSM states.
// Status codes are also consumed by the read-data routing logic.
package slave_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_W_GRANT = 2'd1;
    localparam logic [1:0] ST_W_ACK   = 2'd2;
    localparam logic [1:0] ST_W_DATA  = 2'd3;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_RDATA = 2'd2
    } state_e;

    // Status seen by master idx given the upcoming FSM state/owner and whether it is still pending.
    function automatic logic [1:0] stat_of(state_e st, logic own, logic idx, logic pend);
        if (st == S_GRANT && own == idx) return ST_W_ACK;
        if (st == S_RDATA && own == idx) return ST_W_DATA;
        if (pend) return ST_W_GRANT;
        return ST_IDLE;
    endfunction

endpackage

// File: rtl/slave_arbiter_rr_arbiter2.sv
// Two-requester round-robin pick used only for the IDLE-state grant decision.
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) gnt_o = ptr_i ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/slave_arbiter.sv
// Per-slave arbiter for the 2x2 interconnect: round-robin grant, ack pulse, read data phase.
// Define SLV_TIMEOUT_EN to add the W_ACK timeout abort and the err output.
module slave_arbiter
    import slave_arbiter_pkg::*;
#(
    parameter logic SLAVE_ID    = 1'b0,
    parameter int   TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_cmd,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_cmd,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        s_req,
    output logic        s_cmd,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_ack,
    output logic [1:0]  stat0,
    output logic [1:0]  stat1,
`ifdef SLV_TIMEOUT_EN
    output logic        err,
`endif
    output logic        owner
);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        cmd_q, cmd_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  ack_q, ack_d;
    logic        rr_q, rr_d;
    logic [1:0]  stat0_q, stat0_d;
    logic [1:0]  stat1_q, stat1_d;
    logic [1:0]  hit, eh, gnt;

    assign hit[0] = m0_req && (m0_addr[31] == SLAVE_ID);
    assign hit[1] = m1_req && (m1_addr[31] == SLAVE_ID);
    // A master still holding req during its ack cycle must not start a second transaction.
    assign eh = hit & ~ack_q;

    rr_arbiter2 u_rr (
        .req_i (eh),
        .ptr_i (rr_q),
        .gnt_o (gnt)
    );

`ifdef SLV_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    assign cnt_d = (state_q == S_GRANT) ? cnt_q + 1'b1 : '0;
    assign err   = err_q;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ack_d   = 2'b00;
        rr_d    = rr_q;
`ifdef SLV_TIMEOUT_EN
        err_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (|eh) begin
                    state_d = S_GRANT;
                    owner_d = gnt[1];
                    cmd_d   = gnt[1] ? m1_cmd   : m0_cmd;
                    addr_d  = gnt[1] ? m1_addr  : m0_addr;
                    wdata_d = gnt[1] ? m1_wdata : m0_wdata;
                end
            end
            S_GRANT: begin
                if (s_ack) begin
                    ack_d = owner_q ? 2'b10 : 2'b01;
                    if (cmd_q == CMD_WRITE) begin
                        state_d = S_IDLE;
                        rr_d    = ~owner_q;
                    end else begin
                        state_d = S_RDATA;
                    end
                end
`ifdef SLV_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    ack_d   = owner_q ? 2'b10 : 2'b01;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                    rr_d    = ~owner_q;
                end
`endif
            end
            S_RDATA: begin
                state_d = S_IDLE;
                rr_d    = ~owner_q;
            end
            default: state_d = S_IDLE;
        endcase
        stat0_d = stat_of(state_d, owner_d, 1'b0, eh[0] & ~ack_d[0]);
        stat1_d = stat_of(state_d, owner_d, 1'b1, eh[1] & ~ack_d[1]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            cmd_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 2'b00;
            rr_q    <= 1'b0;
            stat0_q <= ST_IDLE;
            stat1_q <= ST_IDLE;
`ifdef SLV_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rr_q    <= rr_d;
            stat0_q <= stat0_d;
            stat1_q <= stat1_d;
`ifdef SLV_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign s_req   = (state_q == S_GRANT);
    assign s_cmd   = cmd_q;
    assign s_addr  = addr_q;
    assign s_wdata = wdata_q;
    assign m0_ack  = ack_q[0];
    assign m1_ack  = ack_q[1];
    assign stat0   = stat0_q;
    assign stat1   = stat1_q;
    assign owner   = owner_q;

endmodule

// File: tb/tb_slave_arbiter.sv
// Directed bench for slave_arbiter (SLAVE_ID=1); define SLV_TIMEOUT_EN to add the timeout scenario.
module tb_slave_arbiter;
    import slave_arbiter_pkg::*;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       mreq, mcmd;
    logic [31:0]      maddr [2];
    logic [31:0]      mwd   [2];
    logic [1:0]       mack;
    logic             s_req, s_cmd, s_ack, owner;
    logic [31:0]      s_addr, s_wdata;
    logic [1:0][1:0]  stat;
`ifdef SLV_TIMEOUT_EN
    logic             err;
`endif
    int               n_cmp = 0;
    int               n_bad = 0;

    always #5 clk = ~clk;

    slave_arbiter #(.SLAVE_ID(1'b1), .TIMEOUT_CYC(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (mreq[0]),
        .m0_cmd   (mcmd[0]),
        .m0_addr  (maddr[0]),
        .m0_wdata (mwd[0]),
        .m0_ack   (mack[0]),
        .m1_req   (mreq[1]),
        .m1_cmd   (mcmd[1]),
        .m1_addr  (maddr[1]),
        .m1_wdata (mwd[1]),
        .m1_ack   (mack[1]),
        .s_req    (s_req),
        .s_cmd    (s_cmd),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_ack    (s_ack),
        .stat0    (stat[0]),
        .stat1    (stat[1]),
`ifdef SLV_TIMEOUT_EN
        .err      (err),
`endif
        .owner    (owner)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sreq", s_req, 0);
        chk("rst_ack", mack, 0);
        chk("rst_stat", stat, 0);
        chk("rst_owner", owner, 0);
        reset = 1'b1;
    endtask

    // Lone transaction from master m; s_ack raised after nwait extra granted cycles.
    task automatic single(input int m, input logic cmd, input logic [31:0] addr,
                          input logic [31:0] wd, input int nwait);
        mreq[m] = 1'b1; mcmd[m] = cmd; maddr[m] = addr; mwd[m] = wd;
        chk("stat_pre", stat[m], ST_IDLE);
        @(negedge clk);
        for (int k = 0; k <= nwait; k++) begin
            chk("sreq", s_req, 1);
            chk("saddr", s_addr, addr);
            chk("scmd", s_cmd, cmd);
            chk("swdata", s_wdata, wd);
            chk("owner", owner, m);
            chk("stat_wack", stat[m], ST_W_ACK);
            chk("ack_early", mack, 0);
            if (k == nwait) s_ack = 1'b1;
            @(negedge clk);
        end
        chk("ack", mack, (m == 1) ? 2'b10 : 2'b01);
        chk("stat_ackcyc", stat[m], cmd ? ST_IDLE : ST_W_DATA);
        chk("sreq_off", s_req, 0);
        mreq[m] = 1'b0; s_ack = 1'b0;
        @(negedge clk);
        chk("ack_pulse", mack, 0);
        chk("stat_after", stat[m], ST_IDLE);
    endtask

    initial begin
        reset = 1'b0; mreq = '0; mcmd = '0; s_ack = 1'b0;
        maddr[0] = '0; maddr[1] = '0; mwd[0] = '0; mwd[1] = '0;
        do_reset();
        @(negedge clk);

        single(0, CMD_WRITE, 32'h8000_0010, 32'hA5A5_0001, 2);
        single(1, CMD_READ,  32'h8000_0004, 32'h0000_0000, 0);

        // simultaneous pair after reset: m0 wins, m1 waits at W_GRANT
        do_reset();
        @(negedge clk);
        mreq = 2'b11; mcmd = 2'b11;
        maddr[0] = 32'h8000_0100; mwd[0] = 32'h1;
        maddr[1] = 32'h8000_0200; mwd[1] = 32'h2;
        @(negedge clk);
        chk("p1_owner", owner, 0);
        chk("p1_addr", s_addr, 32'h8000_0100);
        chk("p1_stat", stat, {ST_W_GRANT, ST_W_ACK});
        s_ack = 1'b1;
        @(negedge clk);
        chk("p1_ack0", mack, 2'b01);
        chk("p1_stat_ack", stat, {ST_W_GRANT, ST_IDLE});
        chk("p1_idle", s_req, 0);
        mreq[0] = 1'b0; s_ack = 1'b0;
        @(negedge clk);
        chk("p1_owner1", owner, 1);
        chk("p1_addr1", s_addr, 32'h8000_0200);
        chk("p1_stat1", stat, {ST_W_ACK, ST_IDLE});
        s_ack = 1'b1;
        @(negedge clk);
        chk("p1_ack1", mack, 2'b10);
        mreq[1] = 1'b0; s_ack = 1'b0;
        @(negedge clk);

        // m0 alone moves priority to m1, so the next pair grants m1 first
        single(0, CMD_WRITE, 32'h8000_0300, 32'h3, 0);
        mreq = 2'b11;
        @(negedge clk);
        chk("p2_owner", owner, 1);
        chk("p2_addr", s_addr, 32'h8000_0200);
        chk("p2_stat", stat, {ST_W_ACK, ST_W_GRANT});
        s_ack = 1'b1;
        @(negedge clk);
        chk("p2_ack1", mack, 2'b10);
        mreq[1] = 1'b0; s_ack = 1'b0;
        @(negedge clk);
        chk("p2_owner0", owner, 0);
        chk("p2_stat0", stat, {ST_IDLE, ST_W_ACK});
        s_ack = 1'b1;
        @(negedge clk);
        chk("p2_ack0", mack, 2'b01);
        mreq[0] = 1'b0; s_ack = 1'b0;
        @(negedge clk);

        // miss on addr[31]; stray s_ack while IDLE is ignored
        mreq[0] = 1'b1; mcmd[0] = CMD_WRITE; maddr[0] = 32'h0000_0040; s_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("miss_sreq", s_req, 0);
            chk("miss_stat", stat[0], ST_IDLE);
            chk("miss_ack", mack, 0);
        end
        mreq[0] = 1'b0; s_ack = 1'b0;
        @(negedge clk);

        // async reset mid-grant, then re-grant; requester drops req before ack
        mreq[1] = 1'b1; mcmd[1] = CMD_READ; maddr[1] = 32'h8000_0050; mwd[1] = 32'hDEAD;
        @(negedge clk);
        chk("rg_sreq", s_req, 1);
        chk("rg_owner", owner, 1);
        #2 reset = 1'b0;
        #1;
        chk("ar_sreq", s_req, 0);
        chk("ar_addr", s_addr, 0);
        chk("ar_wdata", s_wdata, 0);
        chk("ar_owner", owner, 0);
        chk("ar_stat", stat, 0);
        @(negedge clk);
        chk("ar_hold", s_req, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("rg2_sreq", s_req, 1);
        chk("rg2_owner", owner, 1);
        chk("rg2_stat", stat[1], ST_W_ACK);
        mreq[1] = 1'b0;
        @(negedge clk);
        chk("drop_sreq", s_req, 1);
        s_ack = 1'b1;
        @(negedge clk);
        chk("drop_ack", mack, 2'b10);
        chk("drop_wdata", stat[1], ST_W_DATA);
        s_ack = 1'b0;
        @(negedge clk);
        chk("drop_idle", stat[1], ST_IDLE);

`ifdef SLV_TIMEOUT_EN
        mreq[0] = 1'b1; mcmd[0] = CMD_READ; maddr[0] = 32'h8000_0060;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("to_sreq", s_req, 1);
            chk("to_stat", stat[0], ST_W_ACK);
            chk("to_noerr", err, 0);
        end
        @(negedge clk);
        chk("to_ack", mack, 2'b01);
        chk("to_err", err, 1);
        chk("to_stat_end", stat[0], ST_IDLE);
        chk("to_sreq_off", s_req, 0);
        mreq[0] = 1'b0;
        @(negedge clk);
        chk("to_err_pulse", err, 0);
        chk("to_stat_idle", stat[0], ST_IDLE);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/slave_arbiter.md
Name: slave_arbiter

Overview:
- One instance per slave port of the 2-master / 2-slave interconnect.
- Arbitrates master0/master1 requests that target this slave, round-robin.
- Drives the slave request/command bus and sequences each transaction through grant, ack and data phase.
- Publishes per-master 2-bit status (stat0/stat1) consumed by the read-data routing logic, which captures rdata while a master's status is W_DATA.

Parameters:
- SLAVE_ID, 1'b0, slave number of this port; compared with master addr[31].
- TIMEOUT_CYC, 16, max cycles in W_ACK before abort (only with SLV_TIMEOUT_EN).

Ports:
- clk  in  1  clock, all logic on posedge
- reset  in  1  asynchronous, active-low
- m0_req  in  1  master0 request, held until m0_ack
- m0_cmd  in  1  0 = read, 1 = write
- m0_addr  in  32  bit 31 selects slave
- m0_wdata  in  32  write data
- m0_ack  out  1  one-cycle completion pulse to master0
- m1_req, m1_cmd, m1_addr, m1_wdata, m1_ack  same as master0, for master1
- s_req  out  1  request to slave
- s_cmd  out  1  muxed cmd of granted master
- s_addr  out  32  muxed addr of granted master
- s_wdata  out  32  muxed wdata of granted master
- s_ack  in  1  slave accept
- stat0  out  2  master0 status at this slave
- stat1  out  2  master1 status at this slave
- owner  out  1  index of granted master, valid when s_req=1 or state=W_DATA

Behaviour:
- Status encoding:
  - 0 IDLE: no request to this slave.
  - 1 W_GRANT: requesting, not granted.
  - 2 W_ACK: granted, s_req high.
  - 3 W_DATA: read acked, data phase.
- Master n hits this slave when mn_req=1 and mn_addr[31]==SLAVE_ID.
- FSM states:
  - IDLE: any hit -> GRANT on next edge. Both hit -> master indicated by rr_ptr wins. One hit -> that master.
  - GRANT: s_req=1; s_cmd/s_addr/s_wdata registered from the winner at grant. Stays until s_ack=1.
    - On s_ack, next cycle: mn_ack=1 for one cycle.
    - cmd=1 (write) -> IDLE.
    - cmd=0 (read) -> RDATA.
  - RDATA: exactly one cycle; s_req=0; granted master's stat=3 (slave drives rdata this cycle). Then -> IDLE.
- rr_ptr:
  - Toggles to the non-winner each time a transaction completes (write ack or leaving RDATA).
  - Reset value 0 (master0 priority).
- Latency: hit at edge N -> s_req high cycle N+1. s_ack sampled at edge M -> mn_ack high cycle M+1 (and stat=3 if read).
- Minimum transaction: write 2 cycles, read 3 cycles. Back-to-back: re-arbitration from IDLE only, so one IDLE cycle between transactions.
- Ungranted hitting master: stat=1. Dropping req returns it to 0 next cycle.
- Granted master dropping req before ack: ignored; transaction completes normally.
- Non-hitting master: stat=0.
- s_ack while IDLE or RDATA: ignored.
- Reset (any time, including mid-transaction) — all outputs 0, state IDLE, rr_ptr=0:
  - s_req, s_cmd, s_addr, s_wdata, m0_ack, m1_ack, owner, stat0, stat1 all 0.

Optional Feature:
- SLV_TIMEOUT_EN defined:
  - Counter runs in GRANT, cleared on entry.
  - If TIMEOUT_CYC cycles pass without s_ack: s_req drops, state -> IDLE, rr_ptr toggles.
  - Granted master gets mn_ack plus added output err (1 bit, high with that ack); no W_DATA phase.
- Not defined: no counter, no err port; GRANT waits indefinitely.

Decomposition:
- Shared package/include:
  - Status codes ST_IDLE=0, ST_W_GRANT=1, ST_W_ACK=2, ST_W_DATA=3 (also used by read-data routing).
  - CMD_READ=0, CMD_WRITE=1.
  - FSM state encodings.
- Sub-module rr_arbiter2: two request bits + rr_ptr in, one-hot grant out; purely for the IDLE decision.

Test Plan:
- Single write, m0 addr=0x8000_0010, SLAVE_ID=1, s_ack two cycles after s_req -> s_addr=0x8000_0010, s_cmd=1, m0_ack pulse 1 cycle after s_ack, stat0 sequence 0,2,2,2,0.
- Single read, m1 addr=0x0000_0004, SLAVE_ID=0 -> stat1 sequence 2..2,3,0; stat1=3 exactly one cycle, coinciding with m1_ack.
- Simultaneous hits after reset -> m0 granted first (stat1=1 throughout), m1 granted after one IDLE cycle; next simultaneous pair -> m1 first.
- Miss: m0 addr[31]=0 on SLAVE_ID=1 instance -> stat0=0, s_req never asserts.
- Reset asserted while in GRANT -> all outputs 0 immediately (asynchronous); after release, held request re-granted with s_req one cycle later.
- SLV_TIMEOUT_EN, TIMEOUT_CYC=4, s_ack tied 0 -> s_req high 4 cycles, then m0_ack=1 with err=1, stat0 never 3.
